// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the register-file writeback scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_wb_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: combinational.
// Backpressure: non-granted requesters simply see no grant and must hold.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grantIdx
);

  logic found;
  int   idx;

  // Scan requesters starting at ptr, wrapping; take the first one asserted.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the single register-file write port among NREQ writeback requesters; busy scoreboard; sequenced clear.
// Latency: accepted write reaches rf_we/rf_waddr/rf_wdata one cycle after the handshake.
// Backpressure: req_ready is a same-cycle one-hot grant; all requesters are held off during reset and clear.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_addr,
  output logic [2**AW-1:0]   busy_vec,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] LAST_REG = {AW{1'b1}};

  state_t          state;
  logic [PW-1:0]   rrPtr;
  logic [AW-1:0]   clrAddr;
  logic [NREQ-1:0] arbReq;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grantIdx;
  logic            transfer;
  logic            clrLast;
  logic [AW-1:0]   gAddr;
  logic [DW-1:0]   gData;
  logic [2**AW-1:0] busyNext;

  // Only arbitrate in IDLE and never while reset is held.
  assign arbReq = (state == ST_IDLE && !reset) ? req_valid : '0;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) uArb (
    .req      (arbReq),
    .ptr      (rrPtr),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  // Grant is already qualified by valid, so any grant bit is a transfer.
  assign req_ready = grant;
  assign transfer  = |grant;
  assign gAddr     = req_addr[int'(grantIdx)*AW +: AW];
  assign gData     = req_data[int'(grantIdx)*DW +: DW];
  assign clrLast   = (state == ST_CLEAR) && (clrAddr == LAST_REG);

  // Scoreboard update: write clears, reservation sets (set wins), clear exit wipes everything.
  always_comb begin
    busyNext = busy_vec;
    if (state == ST_IDLE && transfer && gAddr != '0)
      busyNext[gAddr] = 1'b0;
    if (rsv_valid && rsv_addr != '0)
      busyNext[rsv_addr] = 1'b1;
    if (clrLast)
      busyNext = '0;
    busyNext[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_vec <= '0;
    else
      busy_vec <= busyNext;
  end

  // Control FSM: arbitration in IDLE, r1..rLAST walk in CLEAR, registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      rrPtr    <= '0;
      clrAddr  <= '0;
      clr_busy <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rf_we <= transfer && (gAddr != '0);
          if (transfer) begin
            rf_waddr <= gAddr;
            rf_wdata <= gData;
            if (int'(grantIdx) == NREQ - 1)
              rrPtr <= '0;
            else
              rrPtr <= grantIdx + 1'b1;
          end
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_busy <= 1'b1;
            clrAddr  <= AW'(1);
          end
        end
        ST_CLEAR: begin
          rf_we    <= 1'b1;
          rf_waddr <= clrAddr;
          rf_wdata <= '0;
          clrAddr  <= clrAddr + 1'b1;
          if (clrAddr == LAST_REG) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a write scoreboard queue and negedge monitor.
// Latency: expected writes are queued at stimulus time, popped when rf_we is seen.
// Backpressure: req_ready is checked directly against hand-computed grants.
module tb_regfile_wb_scheduler;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rsv_valid;
  logic [AW-1:0]      rsv_addr;
  logic [2**AW-1:0]   busy_vec;
  logic               clr_start;
  logic               clr_busy;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t expQ[$];
  int  nChecks = 0;
  int  nFail   = 0;

  localparam logic [DW-1:0] DA = 32'hAAAA_0001;
  localparam logic [DW-1:0] DB = 32'hBBBB_0002;
  localparam logic [DW-1:0] DC = 32'hCCCC_0003;

  regfile_wb_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .busy_vec  (busy_vec),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushW(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    expQ.push_back(w);
  endtask

  // Monitor: every observed register-file write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && rf_we === 1'b1) begin
      nChecks++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL rfwrite_unexpected: got addr %0d data %h expected no write", rf_waddr, rf_wdata);
      end else begin
        wr_t w;
        w = expQ.pop_front();
        if (rf_waddr !== w.a || rf_wdata !== w.d) begin
          nFail++;
          $display("FAIL rfwrite: got addr %0d data %h expected addr %0d data %h",
                   rf_waddr, rf_wdata, w.a, w.d);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    clr_start = 1'b0;

    // Reset state, with requesters pending to confirm req_ready is held low.
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {DC, DB, DA};
    @(negedge clk);
    chk("reset_ready", req_ready, 0);
    chk("reset_we", rf_we, 0);
    chk("reset_waddr", rf_waddr, 0);
    chk("reset_wdata", rf_wdata, 0);
    chk("reset_busy", busy_vec, 0);
    chk("reset_clrbusy", clr_busy, 0);

    // Contention: grants 0,1,2 then 0 again while only req0 stays valid.
    tick(1);
    reset = 1'b0;
    pushW(5, DA); pushW(6, DB); pushW(7, DC); pushW(5, DA);
    @(negedge clk); chk("cont_ready0", req_ready, 3'b001);
    tick(1);
    @(negedge clk); chk("cont_ready1", req_ready, 3'b010);
    tick(1);
    @(negedge clk); chk("cont_ready2", req_ready, 3'b100);
    tick(1);
    req_valid = 3'b001;
    @(negedge clk); chk("cont_ready3", req_ready, 3'b001);
    tick(1);
    req_valid = 3'b000;
    @(negedge clk); chk("idle_ready", req_ready, 0);

    // Scoreboard: reserve r9, then req1 writes r9 (pointer is at 1).
    tick(1);
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    tick(1);
    rsv_valid = 1'b0;
    @(negedge clk); chk("busy_set9", busy_vec, 32'h0000_0200);
    tick(1);
    req_valid = 3'b010;
    req_addr  = {5'd7, 5'd9, 5'd5};
    req_data  = {DC, 32'h0000_D00D, DA};
    pushW(9, 32'h0000_D00D);
    @(negedge clk);
    chk("sb_ready1", req_ready, 3'b010);
    chk("busy_hold9", busy_vec, 32'h0000_0200);
    tick(1);
    req_valid = 3'b000;
    @(negedge clk); chk("busy_clr9", busy_vec, 0);

    // Same-cycle reserve and write of r9: set wins (pointer at 2 wraps to req1).
    tick(1);
    req_valid = 3'b010;
    req_data  = {DC, 32'h0000_E00E, DA};
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    pushW(9, 32'h0000_E00E);
    @(negedge clk); chk("same_ready", req_ready, 3'b010);
    tick(1);
    req_valid = 3'b000;
    rsv_valid = 1'b0;
    @(negedge clk); chk("busy_setwins", busy_vec, 32'h0000_0200);

    // r0 write: accepted but never written, scoreboard untouched (pointer 2 wraps to req0).
    tick(1);
    req_valid = 3'b001;
    req_addr  = {5'd7, 5'd6, 5'd0};
    req_data  = {DC, DB, 32'h0000_DEAD};
    @(negedge clk); chk("r0_ready", req_ready, 3'b001);
    tick(1);
    req_valid = 3'b000;
    @(negedge clk);
    chk("r0_we", rf_we, 0);
    chk("r0_busy", busy_vec, 32'h0000_0200);

    // Clear with a coincident transfer from req2 (pointer at 1 -> scan 1,2).
    tick(1);
    req_valid = 3'b100;
    req_addr  = {5'd3, 5'd6, 5'd5};
    req_data  = {32'h0000_F00F, DB, DA};
    clr_start = 1'b1;
    pushW(3, 32'h0000_F00F);
    for (int r = 1; r < 32; r++) pushW(AW'(r), 32'h0);
    @(negedge clk); chk("clr_xfer_ready", req_ready, 3'b100);
    tick(1);
    clr_start = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {DC, DB, DA};
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      chk("clr_busy_hi", clr_busy, 1);
      chk("clr_ready0", req_ready, 0);
      if (i == 7) chk("clr_rsv_set", busy_vec, 32'h0010_0200);
      if (i == 30) req_valid = 3'b000;
      rsv_valid = (i == 5 || i == 30);
      rsv_addr  = (i == 30) ? 5'd4 : 5'd20;
      tick(1);
    end
    rsv_valid = 1'b0;
    @(negedge clk);
    chk("clr_exit_busy", clr_busy, 0);
    chk("clr_exit_vec", busy_vec, 0);
    tick(2);

    // Mid-stream reset: pointer moved to 1, then reset; first grant afterwards is req0.
    req_valid = 3'b001;
    req_addr  = {5'd7, 5'd6, 5'd11};
    req_data  = {DC, DB, 32'h0000_0011};
    pushW(11, 32'h0000_0011);
    tick(1);
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {DC, DB, DA};
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    @(negedge clk);
    #1 reset = 1'b1;
    rsv_valid = 1'b0;
    @(negedge clk);
    chk("mrst_ready", req_ready, 0);
    chk("mrst_we", rf_we, 0);
    chk("mrst_waddr", rf_waddr, 0);
    chk("mrst_wdata", rf_wdata, 0);
    chk("mrst_busy", busy_vec, 0);
    tick(1);
    reset = 1'b0;
    pushW(5, DA);
    @(negedge clk); chk("mrst_first_grant", req_ready, 3'b001);
    tick(1);
    req_valid = 3'b000;
    tick(2);

    // Reset during clear, right after r12 is presented.
    clr_start = 1'b1;
    for (int r = 1; r <= 12; r++) pushW(AW'(r), 32'h0);
    tick(1);
    clr_start = 1'b0;
    tick(12);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("crst_we", rf_we, 0);
    chk("crst_clrbusy", clr_busy, 0);
    tick(1);
    reset = 1'b0;
    req_valid = 3'b010;
    req_addr  = {5'd7, 5'd13, 5'd5};
    req_data  = {DC, 32'h0000_0077, DA};
    pushW(13, 32'h0000_0077);
    @(negedge clk); chk("crst_grant", req_ready, 3'b010);
    tick(1);
    req_valid = 3'b000;
    tick(4);
    @(negedge clk);
    chk("crst_not_resumed", clr_busy, 0);
    chk("queue_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
